tile_mem_sequencer: RTL and testbench
=====================================

// Module: tile_mem_sequencer
// PURPOSE
//  Initiator for the tiled-matmul scratchpad RAM: walks every DIMxDIM output tile, issues load_a/load_w
//  strobes with column-of-A / row-of-W addresses, waits for the systolic array to drain, then issues
//  deload_out strobes with result-row addresses. Sits between the top-level start/done control and the
//  RAM + systolic array; it is the only driver of the RAM's strobe and address inputs.
// PARAMETERS
//  ADDR_WIDTH  10   width of every RAM word address
//  DIM         4    systolic array edge (rows of A / cols of W per tile); power of 2
//  M           8    rows of A (multiple of DIM)
//  K           16   cols of A = rows of W (= row stride of A in RAM)
//  NC          8    cols of W = cols of C (multiple of DIM; row stride of W and C)
//  A_BASE      0    word address of A[0][0], row-major
//  W_BASE      256  word address of W[0][0], row-major
//  C_BASE      512  word address of C[0][0], row-major
//  DRAIN_CYC   8    idle cycles after last feed before first deload (array skew + pipeline)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           begin full matmul; sampled only in IDLE
//  load_a     out  1           RAM A-column read strobe
//  load_w     out  1           RAM W-row read strobe
//  addr_a     out  ADDR_WIDTH  A column base (RAM adds i*K per lane)
//  addr_w     out  ADDR_WIDTH  W row base (RAM adds i per lane)
//  deload_out out  1           RAM result-row write strobe
//  addr_res   out  ADDR_WIDTH  C row base for write
//  row_sel    out  log2(DIM)   array output-row mux select for the row being written
//  acc_clr    out  1           one-cycle accumulator clear to the array at tile start
//  busy       out  1           high from CLEAR through DONE inclusive
//  done       out  1           one-cycle pulse when all tiles written
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, tile/k/row counters 0. Reset mid-operation aborts immediately; no
//   further strobes; partial C contents undefined.
//  States: IDLE -start-> CLEAR (1 cyc, acc_clr=1) -> FEED (K cyc, load_a=load_w=1 each cycle, k=0..K-1)
//   -> DRAIN (DRAIN_CYC cyc, no strobes) -> DELOAD (DIM cyc, deload_out=1, r=0..DIM-1) -> NEXT (1 cyc,
//   advance tile) -> CLEAR if tiles remain else DONE (1 cyc, done=1) -> IDLE.
//  Tile order: tn fastest, tm slowest; tm in 0..M/DIM-1, tn in 0..NC/DIM-1.
//  Address timing: RAM samples address one cycle after its strobe. Each address output therefore holds
//   the value for a strobe in the cycle AFTER that strobe (addr lags strobe by exactly 1 cycle); row_sel
//   lags deload_out identically. Addresses hold last value when no strobe follows.
//  addr_a   = A_BASE + tm*DIM*K + k
//  addr_w   = W_BASE + k*NC + tn*DIM
//  addr_res = C_BASE + (tm*DIM + r)*NC + tn*DIM ;  row_sel = r
//  Arithmetic modulo 2^ADDR_WIDTH; no range checking (parameters must keep regions in range).
//  start while busy ignored; start held high in DONE/IDLE re-launches on the IDLE cycle.
//  Cycles per tile = 1 + K + DRAIN_CYC + DIM + 1; no back-pressure, fixed schedule.
// TESTING (defaults unless stated)
//  1 Reset: assert rst_n=0 mid-FEED -> same-cycle all outputs 0; no strobe after release w/o start.
//  2 Full run: start at cycle 0 -> acc_clr cycle 1; 4 tiles x 30 cyc; done single pulse cycle 121;
//    exactly 64 load_a, 64 load_w, 16 deload_out strobes total.
//  3 Addresses: tile (tm=1,tn=0) k=3 -> addr_a=67, addr_w=280 on cycle after that strobe; tile
//    (1,1) r=2 -> addr_res=564, row_sel=2 on cycle after that deload_out.
//  4 Start ignored: pulse start while busy -> schedule and done timing unchanged vs scenario 2.
//  5 Back-to-back: start held high -> second run's CLEAR begins cycle 123 (IDLE at 122).
//  6 Golden model: RAM + array + random 8-bit A,W -> C region 512..575 matches reference matmul.

Source files
------------

// File: rtl/tile_mem_sequencer.sv
// Scratchpad RAM initiator for tiled matmul: per DIMxDIM output tile it clears the accumulators,
// feeds K A-column/W-row strobes, waits for the array to drain, then writes DIM result rows.
module tile_mem_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DIM        = 4,
    parameter int M          = 8,
    parameter int K          = 16,
    parameter int NC         = 8,
    parameter int A_BASE     = 0,
    parameter int W_BASE     = 256,
    parameter int C_BASE     = 512,
    parameter int DRAIN_CYC  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic                                  load_a,
    output logic                                  load_w,
    output logic [ADDR_WIDTH-1:0]                 addr_a,
    output logic [ADDR_WIDTH-1:0]                 addr_w,
    output logic                                  deload_out,
    output logic [ADDR_WIDTH-1:0]                 addr_res,
    output logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] row_sel,
    output logic                                  acc_clr,
    output logic                                  busy,
    output logic                                  done
);

    localparam int TM_N    = M / DIM;
    localparam int TN_N    = NC / DIM;
    localparam int TMW     = (TM_N > 1) ? $clog2(TM_N) : 1;
    localparam int TNW     = (TN_N > 1) ? $clog2(TN_N) : 1;
    localparam int RSW     = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int MAX_KD  = (K > DRAIN_CYC) ? K : DRAIN_CYC;
    localparam int CNT_MAX = (MAX_KD > DIM) ? MAX_KD : DIM;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]  K_LAST     = CW'(K - 1);
    localparam logic [CW-1:0]  DRAIN_LAST = CW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0]  DIM_LAST   = CW'(DIM - 1);
    localparam logic [TMW-1:0] TM_LAST    = TMW'(TM_N - 1);
    localparam logic [TNW-1:0] TN_LAST    = TNW'(TN_N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        DELOAD = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t          state_r, state_n;
    logic [CW-1:0]   cnt_r, cnt_n;
    logic [TMW-1:0]  tm_r, tm_n;
    logic [TNW-1:0]  tn_r, tn_n;

    logic                  load_a_r, load_w_r, deload_r, acc_clr_r, busy_r, done_r;
    logic [ADDR_WIDTH-1:0] addr_a_r, addr_w_r, addr_res_r;
    logic [RSW-1:0]        row_sel_r;

    logic [ADDR_WIDTH-1:0] addr_a_s, addr_w_s, addr_res_s;

    // Addresses for the strobe issued in the current cycle (cnt_r is k in FEED, r in DELOAD)
    always_comb begin
        addr_a_s   = ADDR_WIDTH'(A_BASE + int'(tm_r) * DIM * K + int'(cnt_r));
        addr_w_s   = ADDR_WIDTH'(W_BASE + int'(cnt_r) * NC + int'(tn_r) * DIM);
        addr_res_s = ADDR_WIDTH'(C_BASE + (int'(tm_r) * DIM + int'(cnt_r)) * NC + int'(tn_r) * DIM);
    end

    // Next-state, phase counter and tile walk
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        tm_n    = tm_r;
        tn_n    = tn_r;
        case (state_r)
            IDLE: begin
                cnt_n = '0;
                tm_n  = '0;
                tn_n  = '0;
                if (start) begin
                    state_n = CLEAR;
                end else begin
                    state_n = IDLE;
                end
            end
            CLEAR: begin
                cnt_n   = '0;
                state_n = FEED;
            end
            FEED: begin
                if (cnt_r == K_LAST) begin
                    cnt_n   = '0;
                    state_n = DRAIN;
                end else begin
                    cnt_n = cnt_r + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    cnt_n   = '0;
                    state_n = DELOAD;
                end else begin
                    cnt_n = cnt_r + CW'(1);
                end
            end
            DELOAD: begin
                if (cnt_r == DIM_LAST) begin
                    cnt_n   = '0;
                    state_n = NEXT;
                end else begin
                    cnt_n = cnt_r + CW'(1);
                end
            end
            NEXT: begin
                // tn advances fastest; tm steps when tn wraps
                if (tn_r == TN_LAST) begin
                    tn_n = '0;
                    if (tm_r == TM_LAST) begin
                        tm_n    = '0;
                        state_n = DONE;
                    end else begin
                        tm_n    = tm_r + TMW'(1);
                        state_n = CLEAR;
                    end
                end else begin
                    tn_n    = tn_r + TNW'(1);
                    state_n = CLEAR;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                tm_n    = '0;
                tn_n    = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            tm_r    <= '0;
            tn_r    <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            tm_r    <= tm_n;
            tn_r    <= tn_n;
        end
    end

    // Strobes follow the upcoming state; addresses capture one cycle after their strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_a_r   <= 1'b0;
            load_w_r   <= 1'b0;
            deload_r   <= 1'b0;
            acc_clr_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            addr_a_r   <= '0;
            addr_w_r   <= '0;
            addr_res_r <= '0;
            row_sel_r  <= '0;
        end else begin
            acc_clr_r <= (state_n == CLEAR);
            load_a_r  <= (state_n == FEED);
            load_w_r  <= (state_n == FEED);
            deload_r  <= (state_n == DELOAD);
            busy_r    <= (state_n != IDLE);
            done_r    <= (state_n == DONE);
            if (state_r == FEED) begin
                addr_a_r <= addr_a_s;
                addr_w_r <= addr_w_s;
            end
            if (state_r == DELOAD) begin
                addr_res_r <= addr_res_s;
                row_sel_r  <= cnt_r[RSW-1:0];
            end
        end
    end

    assign load_a     = load_a_r;
    assign load_w     = load_w_r;
    assign addr_a     = addr_a_r;
    assign addr_w     = addr_w_r;
    assign deload_out = deload_r;
    assign addr_res   = addr_res_r;
    assign row_sel    = row_sel_r;
    assign acc_clr    = acc_clr_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_tile_mem_sequencer.sv
// Directed bench for tile_mem_sequencer with default parameters; cycle 0 is the IDLE cycle with start high.
module tb_tile_mem_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       load_a, load_w, deload_out, acc_clr, busy, done;
    logic [9:0] addr_a, addr_w, addr_res;
    logic [1:0] row_sel;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [9:0] exp_a, exp_w, exp_res;
    logic [1:0] exp_rs;

    tile_mem_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_a     (load_a),
        .load_w     (load_w),
        .addr_a     (addr_a),
        .addr_w     (addr_w),
        .deload_out (deload_out),
        .addr_res   (addr_res),
        .row_sel    (row_sel),
        .acc_clr    (acc_clr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // {acc_clr, load_a, load_w, deload_out, busy, done} for cycle c of one run (30-cycle tiles)
    function automatic logic [5:0] exp_ctl(input int c);
        int p;
        logic [5:0] v;
        v = 6'b000000;
        if (c >= 1 && c <= 120) begin
            p = (c - 1) % 30;
            v[5] = (p == 0);
            v[4] = (p >= 1 && p <= 16);
            v[3] = (p >= 1 && p <= 16);
            v[2] = (p >= 25 && p <= 28);
            v[1] = 1'b1;
        end else if (c == 121) begin
            v = 6'b000011;
        end
        return v;
    endfunction

    // Advance the expected address registers after the strobes of run-cycle c
    function automatic void model_addr(input int c);
        int p, t, tm, tn;
        if (c >= 1 && c <= 120) begin
            p  = (c - 1) % 30;
            t  = (c - 1) / 30;
            tm = t / 2;
            tn = t % 2;
            if (p >= 1 && p <= 16) begin
                exp_a = 10'(tm * 4 * 16 + (p - 1));
                exp_w = 10'(256 + (p - 1) * 8 + tn * 4);
            end
            if (p >= 25 && p <= 28) begin
                exp_res = 10'(512 + (tm * 4 + (p - 25)) * 8 + tn * 4);
                exp_rs  = 2'(p - 25);
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if ({acc_clr, load_a, load_w, deload_out, busy, done, addr_a, addr_w, addr_res, row_sel} !== 38'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs got %b %h %h %h %h exp all zero",
                     {acc_clr, load_a, load_w, deload_out, busy, done}, addr_a, addr_w, addr_res, row_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec_cnt++;
        if ({acc_clr, load_a, load_w, deload_out, busy, done} !== 6'd0) begin
            err_cnt++;
            $display("FAIL idle_after_reset got %b exp 000000", {acc_clr, load_a, load_w, deload_out, busy, done});
        end
        exp_a = 10'd0; exp_w = 10'd0; exp_res = 10'd0; exp_rs = 2'd0;
    endtask

    task automatic test_full_run(input bit pulse_busy);
        int la = 0, lw = 0, dl = 0, dn = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 125; c++) begin
            start = (pulse_busy && (c == 40 || c == 121)) ? 1'b1 : 1'b0;
            vec_cnt++;
            if ({acc_clr, load_a, load_w, deload_out, busy, done} !== exp_ctl(c)) begin
                err_cnt++;
                $display("FAIL ctl p%0d c=%0d got %b exp %b", pulse_busy, c,
                         {acc_clr, load_a, load_w, deload_out, busy, done}, exp_ctl(c));
            end
            vec_cnt++;
            if (addr_a !== exp_a || addr_w !== exp_w || addr_res !== exp_res || row_sel !== exp_rs) begin
                err_cnt++;
                $display("FAIL addr c=%0d got a=%0d w=%0d res=%0d rs=%0d exp a=%0d w=%0d res=%0d rs=%0d",
                         c, addr_a, addr_w, addr_res, row_sel, exp_a, exp_w, exp_res, exp_rs);
            end
            if (c == 66) begin
                vec_cnt++;
                if (addr_a !== 10'd67 || addr_w !== 10'd280) begin
                    err_cnt++;
                    $display("FAIL addr_tile10_k3 got a=%0d w=%0d exp a=67 w=280", addr_a, addr_w);
                end
            end
            if (c == 119) begin
                vec_cnt++;
                if (addr_res !== 10'd564 || row_sel !== 2'd2) begin
                    err_cnt++;
                    $display("FAIL addr_tile11_r2 got res=%0d rs=%0d exp res=564 rs=2", addr_res, row_sel);
                end
            end
            la += int'(load_a); lw += int'(load_w); dl += int'(deload_out); dn += int'(done);
            model_addr(c);
            @(posedge clk); #1;
        end
        start = 1'b0;
        vec_cnt++;
        if (la != 64 || lw != 64 || dl != 16 || dn != 1) begin
            err_cnt++;
            $display("FAIL strobe_counts got la=%0d lw=%0d dl=%0d done=%0d exp 64 64 16 1", la, lw, dl, dn);
        end
    endtask

    task automatic test_back_to_back();
        int c1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 248; c++) begin
            if (c == 200) start = 1'b0;
            c1 = (c > 122) ? c - 122 : c;
            vec_cnt++;
            if ({acc_clr, load_a, load_w, deload_out, busy, done} !== exp_ctl(c1)) begin
                err_cnt++;
                $display("FAIL b2b_ctl c=%0d got %b exp %b", c,
                         {acc_clr, load_a, load_w, deload_out, busy, done}, exp_ctl(c1));
            end
            if (c == 123) begin
                vec_cnt++;
                if (acc_clr !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL b2b_relaunch got acc_clr=%b exp 1 at cycle 123", acc_clr);
                end
            end
            vec_cnt++;
            if (addr_a !== exp_a || addr_w !== exp_w || addr_res !== exp_res || row_sel !== exp_rs) begin
                err_cnt++;
                $display("FAIL b2b_addr c=%0d got a=%0d w=%0d res=%0d rs=%0d exp a=%0d w=%0d res=%0d rs=%0d",
                         c, addr_a, addr_w, addr_res, row_sel, exp_a, exp_w, exp_res, exp_rs);
            end
            model_addr(c1);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_feed();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        vec_cnt++;
        if (load_a !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset_feed got load_a=%b exp 1", load_a);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({acc_clr, load_a, load_w, deload_out, busy, done, addr_a, addr_w, addr_res, row_sel} !== 38'd0) begin
            err_cnt++;
            $display("FAIL mid_reset_outputs got %b %h %h %h %h exp all zero",
                     {acc_clr, load_a, load_w, deload_out, busy, done}, addr_a, addr_w, addr_res, row_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            vec_cnt++;
            if ({acc_clr, load_a, load_w, deload_out, busy, done} !== 6'd0) begin
                err_cnt++;
                $display("FAIL post_reset_quiet c=%0d got %b exp 000000", c,
                         {acc_clr, load_a, load_w, deload_out, busy, done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_run(1'b0);
        test_full_run(1'b1);
        test_back_to_back();
        test_reset_mid_feed();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
